nvm_access_scheduler: RTL and testbench
=======================================

# nvm_access_scheduler

Sequencing controller between the two flash-access requesters and the flash interface. Requester 0 is the AHB slave/SOC interface path; requester 1 is the remapping-table page-copy engine. The block arbitrates round-robin between them and programs the flash CSR window (`CSR_offset`/`CSR_length`). It streams exactly `length` words through the flash write/read FIFOs with full/empty back-pressure, checks write permission, and reports completion or error to the granted requester.

## Interface
Parameters:
- `BLK_W`, 16, width of block offsets/lengths (`block_t`)
- `DATA_W`, 32, data word width (`word_t`)

Ports:
- `CLK`  in  1  system clock, rising edge
- `nRST`  in  1  reset, asynchronous, active-low
- `req`  in  2  per-requester transaction request; held high until `done`
- `req_write`  in  2  per-requester direction: 1 = write, 0 = read
- `offset0`, `offset1`  in  BLK_W each  start block per requester
- `length0`, `length1`  in  BLK_W each  word count per requester
- `write_permission`  in  BLK_W  lowest writable block; writes below it are rejected
- `grant`  out  2  one-hot owner of current transaction
- `done`  out  1  one-cycle pulse at transaction end (success or error)
- `err`  out  1  one-cycle pulse coincident with `done` on a rejected transaction
- `src_wdata`  in  DATA_W  write word from the granted requester
- `src_wvalid`  in  1  `src_wdata` valid
- `src_wready`  out  1  write word accepted this cycle
- `src_rdata`  out  DATA_W  registered read word
- `src_rvalid`  out  1  `src_rdata` valid, one-cycle pulse per word
- `CSR_offset`, `CSR_length`  out  BLK_W each  flash command window; registered, held during the transaction
- `CSR_start`  out  1  one-cycle command launch pulse
- `CSR_write`  out  1  command direction, held with `CSR_offset`
- `flash_busy`  in  1  flash interface is executing a command
- `W_data`  out  DATA_W; `W_enable` out 1; `W_full` in 1  flash write FIFO
- `R_data`  in  DATA_W; `R_enable` out 1; `R_empty` in 1  flash read FIFO

## Operation
- FSM states: IDLE, CHECK, ISSUE, WRITE, READ, WAIT, DONE, ERR.
- IDLE: if any `req` is high, pick a winner round-robin against `last_grant`, which resets to 1 so requester 0 wins the first contention. Latch that requester's offset, length and direction, and set `grant`. Go to CHECK.
- Single request: that requester wins regardless of `last_grant`.
- CHECK → ERR if any of the following holds; otherwise → ISSUE:
  - length == 0;
  - offset + length > 2^BLK_W (computed at BLK_W+1 bits);
  - write with offset < `write_permission`.
- ISSUE: `CSR_start` = 1 for one cycle. Then go to WRITE or READ. Word counter cleared to 0.
- WRITE:
  - `src_wready` = `W_enable` = `!W_full`.
  - `W_data` = `src_wdata`, combinational pass-through.
  - The counter increments on each `src_wvalid & src_wready`. When the counter reaches length-1 and a transfer occurs, go to WAIT.
- READ:
  - `R_enable` = `!R_empty`.
  - Each pop registers `R_data` into `src_rdata` and raises `src_rvalid` the next cycle.
  - The counter increments per pop. The last pop goes to WAIT; its `src_rvalid` appears in the first WAIT cycle.
- WAIT: leave to DONE on the first cycle `flash_busy` == 0.
- DONE or ERR:
  - `done` = 1; ERR also drives `err` = 1.
  - `grant` drops the next cycle, `last_grant` is updated, and the FSM returns to IDLE.
  - A requester that keeps `req` high after `done` re-arbitrates, so back-to-back transactions get the IDLE→CHECK overhead.
- ERR never asserts `CSR_start`, `W_enable` or `R_enable`.
- Requester inputs are ignored outside IDLE; the latched values govern the transaction.
- Non-granted requesters see `src_wready` = `src_rvalid` = 0 through `grant` qualification.

## Timing
- Reset values: all outputs 0, including `grant`, `CSR_*`, `done`, `err`, `src_rvalid` and `src_rdata`. FSM = IDLE, `last_grant` = 1.
- Reset mid-transaction returns to IDLE immediately. FIFOs are not flushed by this block.
- Latency from `req` rising to `CSR_start`: 2 cycles (IDLE→CHECK→ISSUE).
- Write throughput: 1 word/cycle when `!W_full` and `src_wvalid` hold.
- Read throughput: 1 word/cycle when `!R_empty`.
- `W_full` or `R_empty` stalls the counter with no word lost or duplicated.
- Minimum transaction for length 1 with no stalls and `flash_busy` already low: IDLE, CHECK, ISSUE, XFER, WAIT, DONE, which is 6 cycles.
- `flash_busy` high at WAIT entry holds WAIT indefinitely, with no timeout.
- `CSR_offset`, `CSR_length` and `CSR_write` are valid from the ISSUE cycle through DONE.

## Test plan
- Single read: req0, offset 0x0010, length 4, `R_empty` low → `CSR_start` 2 cycles after `req`, 4 `R_enable` pulses, 4 `src_rvalid`, `done` once `flash_busy` is 0, `err` = 0.
- Write with back-pressure: req1 write, offset 0x0100, length 3, `write_permission` 0x0080, `W_full` high for 2 cycles mid-burst → exactly 3 `W_enable` pulses, no `W_enable` while full, then `done`.
- Permission and length errors: write offset 0x0040 with `write_permission` 0x0080 → `done` and `err` in the same cycle, no `CSR_start`. Repeat with length 0, and with offset 0xFFFF and length 2 → `err` each time.
- Contention: req0 and req1 rise in the same cycle after reset → requester 0 granted first, requester 1 next. Both held again → alternation 0,1,0,1.
- Flash busy: after the last write word, hold `flash_busy` high 5 cycles → FSM stays in WAIT, `done` 1 cycle after `flash_busy` falls.
- Reset mid-read: deassert `nRST` after 2 of 8 words → all outputs 0 asynchronously. After release, a new req0 starts cleanly with `last_grant` = 1.

Source files
------------

// File: rtl/nvm_access_scheduler.sv
// Round-robin sequencer between the SOC path (req 0) and the page-copy engine (req 1) and the flash CSR/FIFO interface.
// CSR_start two cycles after req; W_full / R_empty stall the word counter, flash_busy holds WAIT.
module nvm_access_scheduler #(
  parameter int BLK_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        req,
  input  logic [1:0]        req_write,
  input  logic [BLK_W-1:0]  offset0,
  input  logic [BLK_W-1:0]  offset1,
  input  logic [BLK_W-1:0]  length0,
  input  logic [BLK_W-1:0]  length1,
  input  logic [BLK_W-1:0]  write_permission,
  output logic [1:0]        grant,
  output logic              done,
  output logic              err,
  input  logic [DATA_W-1:0] src_wdata,
  input  logic              src_wvalid,
  output logic              src_wready,
  output logic [DATA_W-1:0] src_rdata,
  output logic              src_rvalid,
  output logic [BLK_W-1:0]  CSR_offset,
  output logic [BLK_W-1:0]  CSR_length,
  output logic              CSR_start,
  output logic              CSR_write,
  input  logic              flash_busy,
  output logic [DATA_W-1:0] W_data,
  output logic              W_enable,
  input  logic              W_full,
  input  logic [DATA_W-1:0] R_data,
  output logic              R_enable,
  input  logic              R_empty
);

  typedef logic [BLK_W-1:0]  block_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE, CHECK, ISSUE, WRITE, READ, WAIT, DONE, ERR
  } state_t;

  state_t state, state_nxt;

  logic   last_grant;
  block_t xfer_offset;
  block_t xfer_length;
  logic   xfer_write;
  block_t word_cnt;

  logic           arb_sel;
  logic [BLK_W:0] range_end;
  logic           check_fail;
  logic           wr_fire;
  logic           rd_fire;
  logic           last_word;
  block_t         len_m1;

  // Contention goes to the requester that was not served last; a lone request always wins.
  always_comb begin
    arb_sel = 1'b0;
    if (req == 2'b11) begin
      arb_sel = ~last_grant;
    end else begin
      arb_sel = req[1] & ~req[0];
    end
  end

  assign range_end  = {1'b0, xfer_offset} + {1'b0, xfer_length};
  assign check_fail = (xfer_length == '0)
                    | (range_end > {1'b1, {BLK_W{1'b0}}})
                    | (xfer_write & (xfer_offset < write_permission));

  assign len_m1    = xfer_length - 1'b1;
  assign last_word = (word_cnt == len_m1);
  assign wr_fire   = (state == WRITE) & src_wvalid & ~W_full;
  assign rd_fire   = (state == READ) & ~R_empty;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = CHECK;
      CHECK:   state_nxt = check_fail ? ERR : ISSUE;
      ISSUE:   state_nxt = xfer_write ? WRITE : READ;
      WRITE:   if (wr_fire && last_word) state_nxt = WAIT;
      READ:    if (rd_fire && last_word) state_nxt = WAIT;
      WAIT:    if (!flash_busy) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign CSR_start  = (state == ISSUE);
  assign done       = (state == DONE) | (state == ERR);
  assign err        = (state == ERR);
  assign src_wready = (state == WRITE) & ~W_full & (|grant);
  assign W_enable   = wr_fire;
  assign W_data     = (state == WRITE) ? src_wdata : word_t'(0);
  assign R_enable   = rd_fire;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 2'b00;
      xfer_offset <= '0;
      xfer_length <= '0;
      xfer_write  <= 1'b0;
      word_cnt    <= '0;
      CSR_offset  <= '0;
      CSR_length  <= '0;
      CSR_write   <= 1'b0;
      src_rdata   <= '0;
      src_rvalid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      src_rvalid <= rd_fire;
      if (rd_fire) begin
        src_rdata <= R_data;
      end
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= arb_sel ? 2'b10 : 2'b01;
            xfer_offset <= arb_sel ? offset1 : offset0;
            xfer_length <= arb_sel ? length1 : length0;
            xfer_write  <= req_write[arb_sel];
          end
        end
        CHECK: begin
          // The window is only published for transactions that will actually run.
          if (!check_fail) begin
            CSR_offset <= xfer_offset;
            CSR_length <= xfer_length;
            CSR_write  <= xfer_write;
          end
        end
        ISSUE: word_cnt <= '0;
        WRITE: if (wr_fire) word_cnt <= word_cnt + 1'b1;
        READ:  if (rd_fire) word_cnt <= word_cnt + 1'b1;
        DONE, ERR: begin
          grant      <= 2'b00;
          last_grant <= grant[1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_access_scheduler.sv
// Directed bench for nvm_access_scheduler with FIFO models and read/write data scoreboards.
module tb_nvm_access_scheduler;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  req_write = '0;
  logic [15:0] offset0 = '0, offset1 = '0, length0 = '0, length1 = '0;
  logic [15:0] write_permission = '0;
  logic [1:0]  grant;
  logic        done, err;
  logic [31:0] src_wdata = '0;
  logic        src_wvalid = 1'b0;
  logic        src_wready;
  logic [31:0] src_rdata;
  logic        src_rvalid;
  logic [15:0] CSR_offset, CSR_length;
  logic        CSR_start, CSR_write;
  logic        flash_busy = 1'b0;
  logic [31:0] W_data;
  logic        W_enable;
  logic        W_full = 1'b0;
  logic [31:0] R_data = '0;
  logic        R_enable;
  logic        R_empty = 1'b1;

  nvm_access_scheduler #(.BLK_W(16), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .req_write(req_write),
    .offset0(offset0), .offset1(offset1), .length0(length0), .length1(length1),
    .write_permission(write_permission), .grant(grant), .done(done), .err(err),
    .src_wdata(src_wdata), .src_wvalid(src_wvalid), .src_wready(src_wready),
    .src_rdata(src_rdata), .src_rvalid(src_rvalid),
    .CSR_offset(CSR_offset), .CSR_length(CSR_length), .CSR_start(CSR_start),
    .CSR_write(CSR_write), .flash_busy(flash_busy),
    .W_data(W_data), .W_enable(W_enable), .W_full(W_full),
    .R_data(R_data), .R_enable(R_enable), .R_empty(R_empty)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int start_cnt = 0, wen_cnt = 0, ren_cnt = 0, rv_cnt = 0;
  logic [31:0] rfifo[$], rexp[$], wsrc[$], wexp[$];
  logic rd_pop = 1'b0, wr_pop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_done(input string tag, output logic e, output logic [1:0] g);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!done && n < 200);
    chk({tag, "_done_seen"}, done, 1'b1);
    e = err;
    g = grant;
  endtask

  // Flash FIFO and source models: pops decided at the negedge take effect after the next posedge.
  always @(posedge CLK) begin
    logic [31:0] tmp;
    #1;
    if (rd_pop && rfifo.size() > 0) tmp = rfifo.pop_front();
    if (wr_pop && wsrc.size() > 0) tmp = wsrc.pop_front();
    rd_pop = 1'b0;
    wr_pop = 1'b0;
    R_data     = (rfifo.size() > 0) ? rfifo[0] : 32'h0;
    R_empty    = (rfifo.size() == 0);
    src_wdata  = (wsrc.size() > 0) ? wsrc[0] : 32'h0;
    src_wvalid = (wsrc.size() > 0);
  end

  always @(negedge CLK) begin
    if (nRST) begin
      if (CSR_start) start_cnt++;
      if (R_enable) begin
        ren_cnt++;
        rd_pop = 1'b1;
      end
      if (W_enable) begin
        wen_cnt++;
        wr_pop = 1'b1;
        chk("wen_while_full", W_full, 1'b0);
        if (wexp.size() > 0) chk("wdata", W_data, wexp.pop_front());
        else chk("wdata_unexpected", W_data, 32'hxxxx_xxxx);
      end
      if (src_rvalid) begin
        rv_cnt++;
        if (rexp.size() > 0) chk("rdata", src_rdata, rexp.pop_front());
        else chk("rdata_unexpected", src_rdata, 32'hxxxx_xxxx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    logic [1:0] g;
    logic [31:0] w;
    int lat, n, s0, r0, v0, w0;
    bit          cw[5] = '{1, 0, 0, 0, 1};
    logic [15:0] co[5] = '{16'h0040, 16'h0100, 16'hFFFF, 16'hFFFE, 16'h0080};
    logic [15:0] cl[5] = '{16'd4, 16'd0, 16'd2, 16'd2, 16'd1};
    bit          ce[5] = '{1, 1, 1, 0, 0};

    // Reset values
    #1 nRST = 1'b0;
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_csr_start", CSR_start, 1'b0);
    chk("rst_csr_offset", CSR_offset, 16'h0);
    chk("rst_rvalid", src_rvalid, 1'b0);
    chk("rst_rdata", src_rdata, 32'h0);
    chk("rst_wen", W_enable, 1'b0);
    step(); step();
    nRST = 1'b1;
    step();

    // Single read of 4 words
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      rfifo.push_back(w);
      rexp.push_back(w);
    end
    step();
    s0 = start_cnt; r0 = ren_cnt; v0 = rv_cnt;
    offset0 = 16'h0010; length0 = 16'd4; req_write = 2'b00; req = 2'b01;
    lat = 0;
    @(negedge CLK);
    while (!CSR_start && lat < 20) begin
      lat++;
      @(negedge CLK);
    end
    chk("rd_start_latency", lat, 2);
    chk("rd_grant", grant, 2'b01);
    chk("rd_csr_offset", CSR_offset, 16'h0010);
    chk("rd_csr_length", CSR_length, 16'd4);
    chk("rd_csr_write", CSR_write, 1'b0);
    wait_done("rd", e, g);
    chk("rd_err", e, 1'b0);
    step();
    req = 2'b00;
    chk("rd_starts", start_cnt - s0, 1);
    chk("rd_ren", ren_cnt - r0, 4);
    chk("rd_rvalid", rv_cnt - v0, 4);
    chk("rd_sb_empty", rexp.size(), 0);

    // Write of 3 words from requester 1 with two W_full cycles mid-burst
    write_permission = 16'h0080;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      wsrc.push_back(w);
      wexp.push_back(w);
    end
    step();
    w0 = wen_cnt;
    offset1 = 16'h0100; length1 = 16'd3; req_write = 2'b10; req = 2'b10;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!W_enable && n < 50);
    chk("wr_first_wen", W_enable, 1'b1);
    step();
    W_full = 1'b1;
    @(negedge CLK);
    chk("wr_full_wready", src_wready, 1'b0);
    step(); step();
    W_full = 1'b0;
    wait_done("wr", e, g);
    chk("wr_err", e, 1'b0);
    chk("wr_grant", g, 2'b10);
    chk("wr_csr_write", CSR_write, 1'b1);
    chk("wr_csr_offset", CSR_offset, 16'h0100);
    step();
    req = 2'b00;
    chk("wr_wen", wen_cnt - w0, 3);
    chk("wr_sb_empty", wexp.size(), 0);

    // Permission, zero length, range overflow, and the accepted edges
    for (int k = 0; k < 5; k++) begin
      if (!ce[k]) begin
        for (int i = 0; i < cl[k]; i++) begin
          w = $urandom;
          if (cw[k]) begin wsrc.push_back(w); wexp.push_back(w); end
          else begin rfifo.push_back(w); rexp.push_back(w); end
        end
      end
      step();
      s0 = start_cnt;
      offset0 = co[k]; length0 = cl[k]; req_write = {1'b0, cw[k]}; req = 2'b01;
      wait_done($sformatf("case%0d", k), e, g);
      chk($sformatf("case%0d_err", k), e, ce[k]);
      step();
      req = 2'b00;
      chk($sformatf("case%0d_starts", k), start_cnt - s0, ce[k] ? 0 : 1);
    end
    chk("cases_sb_empty", rexp.size() + wexp.size(), 0);

    // flash_busy held in WAIT after the last write word
    flash_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      wsrc.push_back(w);
      wexp.push_back(w);
    end
    step();
    w0 = wen_cnt;
    offset0 = 16'h0200; length0 = 16'd2; req_write = 2'b01; req = 2'b01;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (wen_cnt - w0 < 2 && n < 50);
    chk("busy_words", wen_cnt - w0, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("busy_hold%0d", i), done, 1'b0);
    end
    flash_busy = 1'b0;
    @(negedge CLK);
    chk("busy_release_done", done, 1'b1);
    chk("busy_release_err", err, 1'b0);
    step();
    req = 2'b00;

    // Reset in the middle of an 8-word read
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      rfifo.push_back(w);
      rexp.push_back(w);
    end
    step();
    v0 = rv_cnt;
    offset0 = 16'h0000; length0 = 16'd8; req_write = 2'b00; req = 2'b01;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (rv_cnt - v0 < 2 && n < 50);
    chk("mid_rvalid_count", rv_cnt - v0, 2);
    #1 nRST = 1'b0;
    #1;
    chk("mid_grant", grant, 2'b00);
    chk("mid_rvalid", src_rvalid, 1'b0);
    chk("mid_rdata", src_rdata, 32'h0);
    chk("mid_ren", R_enable, 1'b0);
    chk("mid_csr_length", CSR_length, 16'h0);
    chk("mid_done", done, 1'b0);
    req = 2'b00;
    rfifo.delete();
    rexp.delete();
    rd_pop = 1'b0;
    step(); step();
    nRST = 1'b1;
    step();

    // Contention right after reset: 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      rfifo.push_back(w);
      rexp.push_back(w);
    end
    step();
    offset0 = 16'h0010; length0 = 16'd1;
    offset1 = 16'h0020; length1 = 16'd1;
    req_write = 2'b00; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done($sformatf("arb%0d", k), e, g);
      chk($sformatf("arb%0d_grant", k), g, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("arb%0d_err", k), e, 1'b0);
    end
    step();
    req = 2'b00;
    step(); step();
    chk("final_sb_empty", rexp.size() + wexp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
